// File: rtl/hex_display_scheduler_if.sv
// ----------------------------------------------------------------------------
// hex_display_scheduler_if
//
// Signal bundle between the host logic and the four-digit display scheduler.
//
// Host -> scheduler:
//   enable     1 = display active, 0 = blank display and scroll index held at 0
//   pause      1 = freeze the scroll position (the prescaler keeps running)
//   help_req   level alarm request, highest priority
//   msg_len    message length in characters (0 = none, 17..31 act as 16)
//   wr_en      message-buffer write strobe
//   wr_addr    buffer entry to write
//   wr_char    character code to write
//
// Scheduler -> host:
//   HEX3..HEX0 registered, active-low segment drive (bit 6 = g, bit 0 = a)
//   help_active 1 while the HELP blink is in control
//   pos        scroll index, i.e. the buffer entry shown on HEX3
//   state_dbg  current scheduler state, for observation only
//
// Handshake: there is no back-pressure anywhere on this bundle. A write is a
// single-cycle strobe that is always accepted: wr_en high at a rising edge
// stores wr_char into entry wr_addr at that edge, in every scheduler state.
// All other host inputs are levels sampled on every rising edge.
// ----------------------------------------------------------------------------
interface hex_display_scheduler_if;
    logic       enable;
    logic       pause;
    logic       help_req;
    logic [4:0] msg_len;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_char;
    logic [6:0] HEX3;
    logic [6:0] HEX2;
    logic [6:0] HEX1;
    logic [6:0] HEX0;
    logic       help_active;
    logic [3:0] pos;
    logic [1:0] state_dbg;

    // Host side.
    modport master (
        output enable, pause, help_req, msg_len, wr_en, wr_addr, wr_char,
        input  HEX3, HEX2, HEX1, HEX0, help_active, pos, state_dbg
    );

    // Scheduler side.
    modport slave (
        input  enable, pause, help_req, msg_len, wr_en, wr_addr, wr_char,
        output HEX3, HEX2, HEX1, HEX0, help_active, pos, state_dbg
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// ----------------------------------------------------------------------------
// hex_display_scheduler
//
// Sequencer and arbiter for the four-digit seven-segment display. A 16-entry
// message buffer written by the host is scrolled across HEX3..HEX0 at the
// prescaled tick rate. A HELP request preempts the scroll and blinks "HELP";
// when the request drops the scroll resumes from the index where it stopped.
//
// Parameters:
//   TICK_DIV    CLOCK_50 cycles per scroll/blink tick (>= 2)
//   BLINK_TICKS ticks per HELP on-phase and per off-phase (>= 1)
//
// Ports:
//   CLOCK_50    system clock, all state changes on the rising edge
//   reset_n     asynchronous active-low reset
//   bus         host bundle (slave side), see hex_display_scheduler_if
//
// State values on bus.state_dbg: 0 IDLE, 1 SCROLL, 2 HELP_ON, 3 HELP_OFF.
// ----------------------------------------------------------------------------
module hex_display_scheduler #(
    parameter int TICK_DIV    = 12_500_000,
    parameter int BLINK_TICKS = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    hex_display_scheduler_if.slave        bus
);

    localparam int CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Character codes used for the HELP pattern.
    localparam logic [4:0] CH_H = 5'd16;
    localparam logic [4:0] CH_E = 5'd14;
    localparam logic [4:0] CH_L = 5'd17;
    localparam logic [4:0] CH_P = 5'd18;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCROLL   = 2'd1,
        HELP_ON  = 2'd2,
        HELP_OFF = 2'd3
    } state_t;

    state_t state_q, state_n;

    logic [CNT_W-1:0]   presc_q;
    logic               tick;
    logic [BLINK_W-1:0] blink_q, blink_n;
    logic [3:0]         pos_q, pos_n;
    logic [4:0]         msg_buf [16];
    logic [6:0]         hex_q [4];
    logic [6:0]         hex_n [4];
    logic               help_active_q;

    logic [4:0]         len_eff;
    logic               run;
    logic [4:0]         pos_inc;

    // ------------------------------------------------------------------------
    // Character code to active-low segment pattern (bit 6 = g, bit 0 = a).
    // ------------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'b1000000;
            5'd1:    seg = 7'b1111001;
            5'd2:    seg = 7'b0100100;
            5'd3:    seg = 7'b0110000;
            5'd4:    seg = 7'b0011001;
            5'd5:    seg = 7'b0010010;
            5'd6:    seg = 7'b0000010;
            5'd7:    seg = 7'b1111000;
            5'd8:    seg = 7'b0000000;
            5'd9:    seg = 7'b0010000;
            5'd10:   seg = 7'b0001000;
            5'd11:   seg = 7'b0000011;
            5'd12:   seg = 7'b1000110;
            5'd13:   seg = 7'b0100001;
            5'd14:   seg = 7'b0000110;
            5'd15:   seg = 7'b0001110;
            5'd16:   seg = 7'b0001001;
            5'd17:   seg = 7'b1000111;
            5'd18:   seg = 7'b0001100;
            5'd19:   seg = 7'b0111111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // (pos + k) mod len for k in 0..3. With pos < len the sum is below
    // len + 3, so three conditional subtractions are enough even for len = 1,
    // where every digit folds back onto entry 0.
    // ------------------------------------------------------------------------
    function automatic logic [3:0] wrap_idx(input logic [4:0] sum, input logic [4:0] len);
        logic [4:0] r;
        r = sum;
        for (int i = 0; i < 3; i++) begin
            if (len != 5'd0 && r >= len) begin
                r = r - len;
            end
        end
        return r[3:0];
    endfunction

    // ------------------------------------------------------------------------
    // Effective length and run condition.
    // ------------------------------------------------------------------------
    assign len_eff = (bus.msg_len > 5'd16) ? 5'd16 : bus.msg_len;
    assign run     = bus.enable && (len_eff != 5'd0);
    assign pos_inc = {1'b0, pos_q} + 5'd1;

    // ------------------------------------------------------------------------
    // Free-running prescaler; only reset ever clears it.
    // ------------------------------------------------------------------------
    assign tick = (presc_q == CNT_LAST);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Message buffer. Writes are accepted in every state.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                msg_buf[i] <= 5'd31;
            end
        end else if (bus.wr_en) begin
            msg_buf[bus.wr_addr] <= bus.wr_char;
        end
    end

    // ------------------------------------------------------------------------
    // State, blink counter and scroll index registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            blink_q       <= '0;
            pos_q         <= '0;
            help_active_q <= 1'b0;
        end else begin
            state_q       <= state_n;
            blink_q       <= blink_n;
            pos_q         <= pos_n;
            // Registered from the next state so the flag lines up with the
            // state change rather than trailing it.
            help_active_q <= (state_n == HELP_ON) || (state_n == HELP_OFF);
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. help_req entry beats everything, including a tick in
    // the same cycle. Inside HELP the blink phase change is evaluated before
    // the exit on a dropped request.
    // ------------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        blink_n = blink_q;
        case (state_q)
            IDLE: begin
                if (bus.help_req) begin
                    state_n = HELP_ON;
                    blink_n = '0;
                end else if (run) begin
                    state_n = SCROLL;
                end
            end
            SCROLL: begin
                if (bus.help_req) begin
                    state_n = HELP_ON;
                    blink_n = '0;
                end else if (!run) begin
                    state_n = IDLE;
                end
            end
            HELP_ON, HELP_OFF: begin
                if (tick && blink_q == BLINK_LAST) begin
                    state_n = (state_q == HELP_ON) ? HELP_OFF : HELP_ON;
                    blink_n = '0;
                end else begin
                    if (tick) begin
                        blink_n = blink_q + 1'b1;
                    end
                    if (!bus.help_req) begin
                        state_n = run ? SCROLL : IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                blink_n = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Scroll index. A shrunk length that leaves pos out of range snaps it to 0
    // before anything else; pos is otherwise frozen outside a steady SCROLL.
    // ------------------------------------------------------------------------
    always_comb begin
        pos_n = pos_q;
        if (len_eff != 5'd0 && {1'b0, pos_q} >= len_eff) begin
            pos_n = '0;
        end else if (state_q == SCROLL && state_n == IDLE) begin
            pos_n = '0;
        end else if (state_q == IDLE && !bus.enable) begin
            pos_n = '0;
        end else if (state_q == SCROLL && state_n == SCROLL && tick && !bus.pause) begin
            pos_n = (pos_inc == len_eff) ? 4'd0 : pos_inc[3:0];
        end
    end

    // ------------------------------------------------------------------------
    // Digit contents from the current state, pos and buffer. Index 0 is HEX3.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            hex_n[k] = SEG_BLANK;
        end
        case (state_q)
            SCROLL: begin
                for (int k = 0; k < 4; k++) begin
                    hex_n[k] = glyph(msg_buf[wrap_idx({1'b0, pos_q} + 5'(k), len_eff)]);
                end
            end
            HELP_ON: begin
                hex_n[0] = glyph(CH_H);
                hex_n[1] = glyph(CH_E);
                hex_n[2] = glyph(CH_L);
                hex_n[3] = glyph(CH_P);
            end
            default: begin
                for (int k = 0; k < 4; k++) begin
                    hex_n[k] = SEG_BLANK;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                hex_q[k] <= SEG_BLANK;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                hex_q[k] <= hex_n[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------------
    assign bus.HEX3        = hex_q[0];
    assign bus.HEX2        = hex_q[1];
    assign bus.HEX1        = hex_q[2];
    assign bus.HEX0        = hex_q[3];
    assign bus.help_active = help_active_q;
    assign bus.pos         = pos_q;
    assign bus.state_dbg   = state_q;

endmodule
